dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port word-addressed data memory between two requesters: port 0 (CPU load/store unit) and port 1 (program loader / debug port).
- Round-robin arbitration, a request/acknowledge handshake per port, and a programmable wait-state counter.
- Drives the memory's MemWrite/MemRead/Address/Write_data and captures Read_data.
- Memory reads combinationally and writes on the falling clock edge. The arbiter works on rising edges.

Parameters:
- width, 32, data word width
- AddrWidth, 32, byte-address width
- WAIT_CYCLES, 1, extra ACCESS cycles per transaction (0..15)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, level; held until ack
- we0 / we1  in  1  1 = write, 0 = read; sampled at accept
- addr0 / addr1  in  AddrWidth  byte address; sampled at accept
- wdata0 / wdata1  in  width  write data; sampled at accept
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  width  registered read data, shared by both ports
- err  out  1  misalignment error flag; see Optional Feature
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port owning the current or last transaction
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_addr  out  AddrWidth  to Address
- mem_wdata  out  width  to Write_data
- mem_rdata  in  width  from Read_data

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_grant=1 so port 0 wins the first tie; rdata=0; counter=0. mem_write drops combinationally with rst, so no falling-edge write follows a mid-transaction reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On a rising edge with req0|req1, pick a port and go to ACCESS.
  - Only one request: that port wins. Both requesting: the port != last_grant wins.
  - Latch we/addr/wdata of the winner. Set grant_id=last_grant=winner. Load cnt=WAIT_CYCLES.
- ACCESS:
  - mem_addr/mem_wdata come from latched registers.
  - mem_read=~we_l, mem_write=we_l.
  - Each edge: if cnt==0, capture mem_rdata into rdata (reads only) and go to RESP; else cnt-=1.
  - Writes repeat the same word on each falling edge, which is idempotent.
- RESP: exactly one cycle. ack[grant_id]=1, mem_read=mem_write=0, then go to IDLE.
- Latency: request seen at edge t gives ACCESS cycles t+1..t+1+WAIT_CYCLES and ack in cycle t+2+WAIT_CYCLES. Total is WAIT_CYCLES+3 cycles per transaction, including the IDLE sampling cycle.
- Handshake rules:
  - A requester deasserts req in the cycle after ack or keeps it high for back-to-back access.
  - IDLE always spends at least one cycle between transactions.
  - req changes during ACCESS/RESP are ignored.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- rdata:
  - Updated only by a completed read; writes leave it unchanged.
  - Valid when ack is high and held until the next read completes.
- Address: passed through unmodified; memory discards addr[1:0]. Wrap and out-of-range handling belong to the memory.
- Never assert mem_read and mem_write together. Never assert both acks.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN
- Defined: at accept, if the winner's addr[1:0]!=0, skip ACCESS and go directly to RESP. No mem_read/mem_write is issued. ack and err are both pulsed for that cycle; rdata is unchanged. Arbitration and last_grant still update.
- Undefined: err tied 0. Misaligned addresses are accessed like aligned ones.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - PORT_CPU=1'b0, PORT_DBG=1'b1
  - WAIT_CNT_W=4
- Sub-module dmem_rr_pick: combinational 2-way round-robin pick, inputs req0, req1, last_grant; outputs valid, winner. The top module holds last_grant.

Test Plan:
- Reset then port0 write 0xDEADBEEF to 0x10, WAIT_CYCLES=1 -> mem_write high 2 cycles at addr 0x10, ack0 in 4th cycle after request edge; port0 read of 0x10 -> rdata=0xDEADBEEF with ack0.
- req0 and req1 both high from reset, 4 transactions -> grant_id sequence 0,1,0,1; ack0/ack1 never together.
- Port1 read of a never-written address 0x40 -> rdata=0; a following port1 write -> rdata unchanged.
- Assert rst during ACCESS of a write -> mem_write=0 same cycle, no memory update, all outputs 0, next request starts cleanly from IDLE.
- WAIT_CYCLES=0 and 15 -> ack at request edge+2 and +17 respectively.
- DMEM_ARB_ALIGN_CHECK_EN defined, port0 write to 0x13 -> no mem_write, ack0=err=1 at edge+1; without macro -> normal write to word 4, err=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids,
// wait-state counter width and the alignment helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DBG   = 1'b1;
  localparam int   WAIT_CNT_W = 4;

  // A word access must have the two byte-offset bits clear.
  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin pick. On a tie the port that did not
// win last time gets the grant; a lone requester always wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // Tie goes to the port other than the previous owner.
  always_comb begin
    valid  = req0 | req1;
    winner = PORT_CPU;
    if (req0 && req1) winner = ~last_grant;
    else if (req1)    winner = PORT_DBG;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port word-addressed data memory.
// Round-robin grant, req/ack handshake, WAIT_CYCLES extra access cycles.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN: misaligned accesses are
// rejected with ack+err and never reach the memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int width       = 32,
  parameter int AddrWidth   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [width-1:0]     wdata0,
  input  logic [width-1:0]     wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [width-1:0]     rdata,
  output logic                 err,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [width-1:0]     mem_wdata,
  input  logic [width-1:0]     mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  arb_state_t             state, state_nxt;
  logic                   last_grant;
  logic                   we_l;
  logic [AddrWidth-1:0]   addr_l;
  logic [width-1:0]       wdata_l;
  logic [WAIT_CNT_W-1:0]  cnt;

  logic                   pick_valid;
  logic                   pick_winner;
  logic                   win_we;
  logic [AddrWidth-1:0]   win_addr;
  logic [width-1:0]       win_wdata;
  logic                   skip_access;

  dmem_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign win_we    = pick_winner ? we1    : we0;
  assign win_addr  = pick_winner ? addr1  : addr0;
  assign win_wdata = pick_winner ? wdata1 : wdata0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err_l;

  assign skip_access = misaligned(win_addr[1:0]);

  // Remember whether the accepted transaction was rejected for alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            err_l <= 1'b0;
    else if (state == IDLE && pick_valid) err_l <= skip_access;
  end

  assign err = (state == RESP) & err_l;
`else
  assign skip_access = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state: accept in IDLE, count down in ACCESS, single RESP cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = skip_access ? RESP : ACCESS;
      ACCESS:  if (cnt == '0)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accept-time latching, wait counter and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DBG;
      grant_id   <= PORT_CPU;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      cnt        <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          last_grant <= pick_winner;
          grant_id   <= pick_winner;
          we_l       <= win_we;
          addr_l     <= win_addr;
          wdata_l    <= win_wdata;
          cnt        <= WAIT_INIT;
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_l) rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated with rst so a write can never land on the falling
  // edge that follows a mid-transaction reset.
  assign mem_read  = (state == ACCESS) & ~we_l & ~rst;
  assign mem_write = (state == ACCESS) &  we_l & ~rst;
  assign mem_addr  = addr_l;
  assign mem_wdata = wdata_l;

  assign busy = (state != IDLE);
  assign ack0 = (state == RESP) & (grant_id == PORT_CPU);
  assign ack1 = (state == RESP) & (grant_id == PORT_DBG);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: main instance (WAIT_CYCLES=1) against a
// small falling-edge-write memory model, plus WAIT_CYCLES=0/15 instances for
// latency checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main instance
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, busy, grant_id, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(negedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  dmem_arbiter #(.width(32), .AddrWidth(32), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .grant_id(grant_id), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // latency instances
  logic        a_req, a_ack0, a_ack1, a_err, a_busy, a_gid, a_rd, a_wr;
  logic [31:0] a_rdata, a_maddr, a_mwdata;
  logic        b_req, b_ack0, b_ack1, b_err, b_busy, b_gid, b_rd, b_wr;
  logic [31:0] b_rdata, b_maddr, b_mwdata;

  dmem_arbiter #(.width(32), .AddrWidth(32), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req0(a_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(32'h0), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
    .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .err(a_err), .busy(a_busy),
    .grant_id(a_gid), .mem_read(a_rd), .mem_write(a_wr),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(32'h0)
  );

  dmem_arbiter #(.width(32), .AddrWidth(32), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst),
    .req0(b_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(32'h0), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .err(b_err), .busy(b_busy),
    .grant_id(b_gid), .mem_read(b_rd), .mem_write(b_wr),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main instance. Returns edges from request to
  // ack and the number of cycles mem_write was high at the target address.
  task automatic txn(input logic port, input logic we, input logic [31:0] a,
                     input logic [31:0] d, output int edges, output int wr_cycles);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    edges = 0;
    wr_cycles = 0;
    while (!(ack0 || ack1) && edges < 40) begin
      tick();
      edges++;
      if (mem_write && mem_addr == a) wr_cycles++;
    end
    chk("ack_seen", {31'b0, ack0 | ack1}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int e, w, k, both;
    logic [3:0] exp_g;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    a_req = 0; b_req = 0;

    // reset state
    #2;
    chk("rst_outputs", {ack0, ack1, err, busy, grant_id, mem_read, mem_write},
        32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    @(negedge clk); rst = 1'b0;
    tick();

    // port0 write then read back
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, e, w);
    chk("wr_latency", e, 32'd3);
    chk("wr_cycles", w, 32'd2);
    chk("wr_ack0", {30'b0, ack0, ack1}, 32'b10);
    chk("wr_mem", mem[4], 32'hDEADBEEF);
    tick();
    txn(1'b0, 1'b0, 32'h10, 32'h0, e, w);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_gid", {31'b0, grant_id}, 32'd0);
    tick();

    // port1 read of unwritten word, then write leaves rdata alone
    txn(1'b1, 1'b0, 32'h40, 32'h0, e, w);
    chk("p1_rd_rdata", rdata, 32'h0);
    chk("p1_rd_ack", {30'b0, ack0, ack1}, 32'b01);
    tick();
    txn(1'b1, 1'b1, 32'h44, 32'hAAAA5555, e, w);
    chk("p1_wr_rdata", rdata, 32'h0);
    chk("p1_wr_mem", mem[17], 32'hAAAA5555);
    tick();

    // fairness from reset: both requesting continuously
    @(negedge clk); rst = 1'b1;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h40;
    @(negedge clk); rst = 1'b0;
    exp_g = 4'b1010; // LSB first: 0,1,0,1
    k = 0; both = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      tick();
      if (ack0 && ack1) both++;
      if (ack0 || ack1) begin
        chk("rr_gid", {31'b0, grant_id}, {31'b0, exp_g[k]});
        chk("rr_ack0", {31'b0, ack0}, {31'b0, ~exp_g[k]});
        k++;
      end
    end
    chk("rr_count", k, 32'd4);
    chk("rr_no_double_ack", both, 32'd0);
    req0 = 0; req1 = 0;
    tick(); tick();

    // reset in the middle of a write
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h12345678;
    tick();
    chk("mid_busy", {30'b0, busy, mem_write}, 32'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_mw", {31'b0, mem_write}, 32'd0);
    chk("mid_rst_outs", {ack0, ack1, err, busy, grant_id, mem_read}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    req0 = 0;
    @(negedge clk); #1;
    chk("mid_rst_nomem", mem[8], 32'h0);
    rst = 1'b0;
    tick();
    txn(1'b1, 1'b0, 32'h10, 32'h0, e, w);
    chk("post_rst_lat", e, 32'd3);
    chk("post_rst_rdata", rdata, 32'hDEADBEEF);
    tick();

    // misaligned write
    txn(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, e, w);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_latency", e, 32'd1);
    chk("mis_wr_cycles", w, 32'd0);
    chk("mis_ack_err", {30'b0, ack0, err}, 32'b11);
    chk("mis_mem", mem[4], 32'hDEADBEEF);
`else
    chk("mis_latency", e, 32'd3);
    chk("mis_wr_cycles", w, 32'd2);
    chk("mis_ack_err", {30'b0, ack0, err}, 32'b10);
    chk("mis_mem", mem[4], 32'hCAFEF00D);
`endif
    chk("mis_rdata", rdata, 32'hDEADBEEF);
    tick();

    // WAIT_CYCLES=0 latency
    a_req = 1; e = 0;
    while (!a_ack0 && e < 40) begin tick(); e++; end
    a_req = 0;
    chk("w0_latency", e, 32'd2);
    tick();

    // WAIT_CYCLES=15 latency
    b_req = 1; e = 0;
    while (!b_ack0 && e < 40) begin tick(); e++; end
    b_req = 0;
    chk("w15_latency", e, 32'd17);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
